// File: rtl/wb_spi_host_if.sv
// rtl/wb_spi_host_if.sv - Wishbone classic initiator bundle driven by the SPI bridge
interface wb_spi_host_if;
    logic [31:0] wbm_adr_o;
    logic [31:0] wbm_dat_o;
    logic [31:0] wbm_dat_i;
    logic [3:0]  wbm_sel_o;
    logic        wbm_we_o;
    logic        wbm_cyc_o;
    logic        wbm_stb_o;
    logic        wbm_ack_i;

    modport master (
        output wbm_adr_o, wbm_dat_o, wbm_sel_o, wbm_we_o, wbm_cyc_o, wbm_stb_o,
        input  wbm_dat_i, wbm_ack_i
    );

    modport slave (
        input  wbm_adr_o, wbm_dat_o, wbm_sel_o, wbm_we_o, wbm_cyc_o, wbm_stb_o,
        output wbm_dat_i, wbm_ack_i
    );
endinterface

// File: rtl/wb_spi_host.sv
// rtl/wb_spi_host.sv - SPI target that issues single 32-bit Wishbone classic cycles
module wb_spi_host #(
    parameter int unsigned TIMEOUT  = 48,
    parameter logic [31:0] ERR_WORD = 32'hDEADBEEF
) (
    input  logic          wb_clk_i,
    input  logic          wb_rst_n,
    input  logic          spi_sck,
    input  logic          spi_csn,
    input  logic          spi_mosi,
    output logic          spi_miso,
    output logic          spi_miso_oeb,
    wb_spi_host_if.master wbm,
    output logic          busy,
    output logic          err
);
    localparam logic [7:0] CMD_WRITE = 8'h80;
    localparam logic [7:0] CMD_READ  = 8'h00;
    localparam logic [7:0] TMO_LAST  = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_GUARD, ST_CYCLE, ST_DONE} state_t;

    state_t      state_q, state_d;
    // [0],[1] are the synchroniser stages, [2] is the previous value for edge detect
    logic [2:0]  sck_pipe_q, sck_pipe_d;
    logic [2:0]  csn_pipe_q, csn_pipe_d;
    logic [1:0]  mosi_pipe_q, mosi_pipe_d;
    logic [6:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  cmd_q, cmd_d;
    logic [31:0] shift_q, shift_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] tx_q, tx_d;
    logic        miso_q, miso_d;
    logic        err_q, err_d;
    logic        owner_q, owner_d;
    logic        rd_ready_q, rd_ready_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] adr_q, adr_d;
    logic [31:0] dat_q, dat_d;
    logic        we_q, we_d;
    logic        cyc_q, cyc_d;
    logic [7:0]  tmo_q, tmo_d;

    logic        sck_rise, sck_fall, csn_fall, frame_on;
    logic [31:0] shift_in, tx_word;
    logic        trig, trig_we, err_set;
    logic [31:0] trig_adr;

    assign sck_rise = sck_pipe_q[1] & ~sck_pipe_q[2];
    assign sck_fall = ~sck_pipe_q[1] & sck_pipe_q[2];
    assign csn_fall = ~csn_pipe_q[1] & csn_pipe_q[2];
    assign frame_on = ~csn_pipe_q[1];
    assign shift_in = {shift_q[30:0], mosi_pipe_q[1]};
    assign tx_word  = rd_ready_q ? rdata_q : ERR_WORD;

    always_comb begin
        sck_pipe_d  = {sck_pipe_q[1:0], spi_sck};
        csn_pipe_d  = {csn_pipe_q[1:0], spi_csn};
        mosi_pipe_d = {mosi_pipe_q[0], spi_mosi};
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        cmd_d       = cmd_q;
        shift_d     = shift_q;
        addr_d      = addr_q;
        tx_d        = tx_q;
        miso_d      = miso_q;
        err_d       = err_q;
        owner_d     = owner_q;
        rd_ready_d  = rd_ready_q;
        rdata_d     = rdata_q;
        adr_d       = adr_q;
        dat_d       = dat_q;
        we_d        = we_q;
        cyc_d       = cyc_q;
        tmo_d       = tmo_q;
        trig        = 1'b0;
        trig_we     = 1'b0;
        trig_adr    = addr_q;
        err_set     = 1'b0;

        // Frame decode: command byte, address word, then write data
        if (csn_fall) begin
            bit_cnt_d  = '0;
            cmd_d      = '0;
            shift_d    = '0;
            addr_d     = '0;
            tx_d       = '0;
            err_d      = 1'b0;
            owner_d    = 1'b0;
            rd_ready_d = 1'b0;
        end else if (frame_on && sck_rise) begin
            shift_d = shift_in;
            if (bit_cnt_q != 7'h7F) begin
                bit_cnt_d = bit_cnt_q + 7'd1;
            end
            if (bit_cnt_q == 7'd7) begin
                cmd_d = shift_in[7:0];
            end
            if (bit_cnt_q == 7'd39) begin
                addr_d = shift_in;
                if (cmd_q == CMD_READ) begin
                    trig     = 1'b1;
                    trig_adr = shift_in;
                end
            end
            if (bit_cnt_q == 7'd71 && cmd_q == CMD_WRITE) begin
                trig    = 1'b1;
                trig_we = 1'b1;
            end
        end

        // Read data goes out on falling edges, first bit after the turnaround byte
        if (!frame_on) begin
            miso_d = 1'b0;
        end else if (sck_fall && cmd_q == CMD_READ) begin
            if (bit_cnt_q == 7'd48) begin
                tx_d   = tx_word;
                miso_d = tx_word[31];
            end else if (bit_cnt_q > 7'd48 && bit_cnt_q < 7'd80) begin
                tx_d   = {tx_q[30:0], 1'b0};
                miso_d = tx_q[30];
            end else begin
                miso_d = 1'b0;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (trig) begin
                    state_d = ST_GUARD;
                    adr_d   = trig_adr;
                    we_d    = trig_we;
                    owner_d = 1'b1;
                    if (trig_we) begin
                        dat_d = shift_in;
                    end
                end
            end
            ST_GUARD: begin
                // A slow responder may still be acking the previous cycle
                if (!wbm.wbm_ack_i) begin
                    cyc_d   = 1'b1;
                    tmo_d   = '0;
                    state_d = ST_CYCLE;
                end
            end
            ST_CYCLE: begin
                if (wbm.wbm_ack_i) begin
                    cyc_d   = 1'b0;
                    state_d = ST_DONE;
                    if (owner_q && !csn_fall && !we_q) begin
                        rdata_d    = wbm.wbm_dat_i;
                        rd_ready_d = 1'b1;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    cyc_d   = 1'b0;
                    err_set = 1'b1;
                    state_d = ST_DONE;
                    if (owner_q && !csn_fall && !we_q) begin
                        rdata_d    = ERR_WORD;
                        rd_ready_d = 1'b1;
                    end
                end else begin
                    tmo_d = tmo_q + 8'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                cyc_d   = 1'b0;
            end
        endcase

        if (trig && state_q != ST_IDLE) begin
            err_set = 1'b1;
        end
        if (err_set) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state_q     <= ST_IDLE;
            sck_pipe_q  <= 3'b000;
            csn_pipe_q  <= 3'b111;
            mosi_pipe_q <= 2'b00;
            bit_cnt_q   <= '0;
            cmd_q       <= '0;
            shift_q     <= '0;
            addr_q      <= '0;
            tx_q        <= '0;
            miso_q      <= 1'b0;
            err_q       <= 1'b0;
            owner_q     <= 1'b0;
            rd_ready_q  <= 1'b0;
            rdata_q     <= '0;
            adr_q       <= '0;
            dat_q       <= '0;
            we_q        <= 1'b0;
            cyc_q       <= 1'b0;
            tmo_q       <= '0;
        end else begin
            state_q     <= state_d;
            sck_pipe_q  <= sck_pipe_d;
            csn_pipe_q  <= csn_pipe_d;
            mosi_pipe_q <= mosi_pipe_d;
            bit_cnt_q   <= bit_cnt_d;
            cmd_q       <= cmd_d;
            shift_q     <= shift_d;
            addr_q      <= addr_d;
            tx_q        <= tx_d;
            miso_q      <= miso_d;
            err_q       <= err_d;
            owner_q     <= owner_d;
            rd_ready_q  <= rd_ready_d;
            rdata_q     <= rdata_d;
            adr_q       <= adr_d;
            dat_q       <= dat_d;
            we_q        <= we_d;
            cyc_q       <= cyc_d;
            tmo_q       <= tmo_d;
        end
    end

    assign wbm.wbm_cyc_o = cyc_q;
    assign wbm.wbm_stb_o = cyc_q;
    assign wbm.wbm_we_o  = cyc_q & we_q;
    assign wbm.wbm_sel_o = {4{cyc_q}};
    assign wbm.wbm_adr_o = adr_q;
    assign wbm.wbm_dat_o = dat_q;
    assign busy          = (state_q != ST_IDLE);
    assign err           = err_q;
    assign spi_miso      = miso_q;
    assign spi_miso_oeb  = csn_pipe_q[1];
endmodule

// File: tb/tb_wb_spi_host.sv
// tb/tb_wb_spi_host.sv - directed bench for wb_spi_host with a Wishbone responder model
module tb_wb_spi_host;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, spi_sck, spi_csn, spi_mosi, spi_miso, spi_miso_oeb, busy, err;
    wb_spi_host_if bus();

    wb_spi_host #(.TIMEOUT(48), .ERR_WORD(32'hDEADBEEF)) dut (
        .wb_clk_i     (clk),
        .wb_rst_n     (rst_n),
        .spi_sck      (spi_sck),
        .spi_csn      (spi_csn),
        .spi_mosi     (spi_mosi),
        .spi_miso     (spi_miso),
        .spi_miso_oeb (spi_miso_oeb),
        .wbm          (bus.master),
        .busy         (busy),
        .err          (err)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Responder: acks ack_lat cycles after cyc, keeps ack high ack_hold extra cycles
    logic        never_ack = 1'b0;
    logic        ack_stuck = 1'b0;
    logic        ack_r;
    logic [31:0] rsp_word = 32'h0;
    int          ack_lat = 2;
    int          ack_hold = 0;
    int          wait_cnt, hold_left;

    assign bus.wbm_ack_i = ack_r | ack_stuck;
    assign bus.wbm_dat_i = ack_r ? rsp_word : 32'h0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_r     <= 1'b0;
            wait_cnt  <= 0;
            hold_left <= 0;
        end else if (ack_r) begin
            if (hold_left > 0) hold_left <= hold_left - 1;
            else ack_r <= 1'b0;
        end else if (bus.wbm_cyc_o && !never_ack) begin
            if (wait_cnt >= ack_lat - 1) begin
                ack_r     <= 1'b1;
                hold_left <= ack_hold;
                wait_cnt  <= 0;
            end else begin
                wait_cnt <= wait_cnt + 1;
            end
        end else begin
            wait_cnt <= 0;
        end
    end

    logic        cyc_prev = 1'b0, ack_prev = 1'b0, ack_raw_prev = 1'b0;
    int          n_cyc = 0, cyc_len = 0, ack_viol = 0, guard_viol = 0, stb_viol = 0;
    logic [31:0] last_adr = 32'h0, last_dat = 32'h0;
    logic        last_we = 1'b0;
    logic [3:0]  last_sel = 4'h0;

    always @(negedge clk) begin
        if (bus.wbm_cyc_o && !cyc_prev) begin
            n_cyc    <= n_cyc + 1;
            cyc_len  <= 1;
            last_adr <= bus.wbm_adr_o;
            last_dat <= bus.wbm_dat_o;
            last_we  <= bus.wbm_we_o;
            last_sel <= bus.wbm_sel_o;
            if (ack_raw_prev) guard_viol <= guard_viol + 1;
        end else if (bus.wbm_cyc_o) begin
            cyc_len <= cyc_len + 1;
        end
        if (bus.wbm_cyc_o && ack_prev) ack_viol <= ack_viol + 1;
        if (bus.wbm_stb_o !== bus.wbm_cyc_o) stb_viol <= stb_viol + 1;
        cyc_prev     <= bus.wbm_cyc_o;
        ack_prev     <= bus.wbm_cyc_o & bus.wbm_ack_i;
        ack_raw_prev <= bus.wbm_ack_i;
    end

    task automatic spi_bit(input logic mo, output logic mi);
        spi_mosi = mo;
        repeat (4) @(negedge clk);
        mi = spi_miso;
        spi_sck = 1'b1;
        repeat (4) @(negedge clk);
        spi_sck = 1'b0;
    endtask

    task automatic spi_frame(input logic [7:0] cmd, input logic [31:0] adr, input logic [31:0] wd,
                             input int nbits, input logic end_frame,
                             output logic [31:0] rd, output logic oeb_seen);
        logic [79:0] tx;
        logic [79:0] rx;
        logic        b;
        tx = {cmd, adr, wd, 8'h00};
        rx = '0;
        spi_csn = 1'b0;
        repeat (4) @(negedge clk);
        oeb_seen = spi_miso_oeb;
        for (int i = 0; i < nbits; i++) begin
            spi_bit(tx[79-i], b);
            rx[79-i] = b;
        end
        if (end_frame) begin
            repeat (4) @(negedge clk);
            spi_csn = 1'b1;
            repeat (8) @(negedge clk);
        end
        rd = rx[31:0];
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy && n < 300) begin
            @(negedge clk);
            n++;
        end
        check_eq(tag, busy, 1'b0);
    endtask

    logic [31:0] rd;
    logic        oeb_seen;
    int          n0;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; spi_sck = 1'b0; spi_csn = 1'b1; spi_mosi = 1'b0;
        repeat (4) @(negedge clk);
        check_eq("rst_cyc",  bus.wbm_cyc_o, 1'b0);
        check_eq("rst_stb",  bus.wbm_stb_o, 1'b0);
        check_eq("rst_we",   bus.wbm_we_o, 1'b0);
        check_eq("rst_sel",  bus.wbm_sel_o, 4'h0);
        check_eq("rst_adr",  bus.wbm_adr_o, 32'h0);
        check_eq("rst_dat",  bus.wbm_dat_o, 32'h0);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_err",  err, 1'b0);
        check_eq("rst_miso", spi_miso, 1'b0);
        check_eq("rst_oeb",  spi_miso_oeb, 1'b1);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // Plain write
        n0 = n_cyc;
        spi_frame(8'h80, 32'h00800000, 32'h00000011, 72, 1'b1, rd, oeb_seen);
        wait_idle("wr_idle");
        check_eq("wr_oeb_in_frame", oeb_seen, 1'b0);
        check_eq("wr_ncyc", n_cyc - n0, 1);
        check_eq("wr_adr",  last_adr, 32'h00800000);
        check_eq("wr_dat",  last_dat, 32'h00000011);
        check_eq("wr_we",   last_we, 1'b1);
        check_eq("wr_sel",  last_sel, 4'hF);
        check_eq("wr_err",  err, 1'b0);
        check_eq("wr_adr_hold", bus.wbm_adr_o, 32'h00800000);
        check_eq("wr_miso_idle", spi_miso, 1'b0);
        check_eq("wr_oeb_after", spi_miso_oeb, 1'b1);

        // Read with a 2-cycle responder
        rsp_word = 32'h12345678;
        n0 = n_cyc;
        spi_frame(8'h00, 32'h00400000, 32'h0, 80, 1'b1, rd, oeb_seen);
        wait_idle("rd_idle");
        check_eq("rd_data", rd, 32'h12345678);
        check_eq("rd_ncyc", n_cyc - n0, 1);
        check_eq("rd_adr",  last_adr, 32'h00400000);
        check_eq("rd_we",   last_we, 1'b0);
        check_eq("rd_err",  err, 1'b0);

        // Read timeout
        never_ack = 1'b1;
        n0 = n_cyc;
        spi_frame(8'h00, 32'h00000010, 32'h0, 80, 1'b1, rd, oeb_seen);
        wait_idle("tmo_idle");
        never_ack = 1'b0;
        check_eq("tmo_ncyc", n_cyc - n0, 1);
        check_eq("tmo_len",  cyc_len, 48);
        check_eq("tmo_err",  err, 1'b1);
        check_eq("tmo_data", rd, 32'hDEADBEEF);

        // Unknown command, then an aborted frame, then a good write
        n0 = n_cyc;
        spi_frame(8'h3C, 32'h00000008, 32'h00000077, 72, 1'b1, rd, oeb_seen);
        check_eq("bad_err_cleared", err, 1'b0);
        spi_frame(8'h80, 32'h00000008, 32'h00000077, 20, 1'b1, rd, oeb_seen);
        repeat (20) @(negedge clk);
        check_eq("bad_abort_ncyc", n_cyc - n0, 0);
        check_eq("bad_abort_busy", busy, 1'b0);
        spi_frame(8'h80, 32'h00000004, 32'h0000A5A5, 72, 1'b1, rd, oeb_seen);
        wait_idle("after_idle");
        check_eq("after_ncyc", n_cyc - n0, 1);
        check_eq("after_adr",  last_adr, 32'h00000004);
        check_eq("after_dat",  last_dat, 32'h0000A5A5);

        // Lingering ack holds the next cycle in GUARD
        ack_lat = 1;
        ack_hold = 3;
        n0 = n_cyc;
        spi_frame(8'h80, 32'h00000100, 32'h00000001, 72, 1'b1, rd, oeb_seen);
        wait_idle("g1_idle");
        ack_stuck = 1'b1;
        spi_frame(8'h80, 32'h00000104, 32'h00000002, 72, 1'b1, rd, oeb_seen);
        check_eq("g2_busy_wait", busy, 1'b1);
        check_eq("g2_cyc_wait",  bus.wbm_cyc_o, 1'b0);
        check_eq("g2_ncyc_wait", n_cyc - n0, 1);
        repeat (3) @(negedge clk);
        ack_stuck = 1'b0;
        wait_idle("g2_idle");
        check_eq("g2_ncyc", n_cyc - n0, 2);
        check_eq("g2_adr",  last_adr, 32'h00000104);
        check_eq("g2_dat",  last_dat, 32'h00000002);
        check_eq("guard_viol", guard_viol, 0);
        check_eq("ack_viol",   ack_viol, 0);
        check_eq("stb_viol",   stb_viol, 0);
        ack_lat = 2;
        ack_hold = 0;

        // Asynchronous reset in the middle of a cycle
        never_ack = 1'b1;
        spi_frame(8'h80, 32'h00000020, 32'h55AA55AA, 72, 1'b0, rd, oeb_seen);
        repeat (4) @(negedge clk);
        check_eq("ar_pre_cyc", bus.wbm_cyc_o, 1'b1);
        check_eq("ar_pre_oeb", spi_miso_oeb, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check_eq("ar_cyc",  bus.wbm_cyc_o, 1'b0);
        check_eq("ar_stb",  bus.wbm_stb_o, 1'b0);
        check_eq("ar_busy", busy, 1'b0);
        check_eq("ar_oeb",  spi_miso_oeb, 1'b1);
        check_eq("ar_adr",  bus.wbm_adr_o, 32'h0);
        spi_csn = 1'b1;
        spi_sck = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        never_ack = 1'b0;
        repeat (4) @(negedge clk);
        rsp_word = 32'hCAFEF00D;
        n0 = n_cyc;
        spi_frame(8'h00, 32'h00000030, 32'h0, 80, 1'b1, rd, oeb_seen);
        wait_idle("post_idle");
        check_eq("post_data", rd, 32'hCAFEF00D);
        check_eq("post_ncyc", n_cyc - n0, 1);
        check_eq("post_adr",  last_adr, 32'h00000030);
        check_eq("post_err",  err, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
